alu_quarter_sequencer: RTL
==========================

# alu_quarter_sequencer

Front-end sequencer for a 16-lane SIMD ALU. It accepts one 64-lane wavefront operand vector and issues it to the ALU as four 16-lane quarters on consecutive cycles. It tracks the ALU pipeline latency and drives the write/shift enables of the downstream 64-lane collection register, which turns the four returning quarter results back into one 64-lane result. It pulses `done` in the first cycle the collected 64-lane result is valid.

## Interface
Parameters:
- `WIDTH`, 32: bits per lane.
- `LATENCY`, 2: ALU pipeline depth in cycles, quarter in to quarter result out; legal range 1..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `issue_valid`  in  1  operand vector offered.
- `issue_ready`  out  1  sequencer can accept; high only in IDLE with `flush` low.
- `issue_data`  in  64*WIDTH  operand vector; lane i is bits [i*WIDTH +: WIDTH].
- `flush`  in  1  synchronous abort of the current wavefront.
- `lane_valid`  out  1  a quarter is presented to the ALU this cycle.
- `lane_data`  out  16*WIDTH  current quarter, lanes 16q..16q+15; zero when `lane_valid`=0.
- `quarter_idx`  out  2  index q of the presented quarter; 0 when idle.
- `out_wr_en`  out  1  low-line write enable of the collection register.
- `out_shift_en`  out  1  shift enable of the collection register.
- `done`  out  1  one-cycle pulse: collected 64-lane result valid this cycle.
- `busy`  out  1  state is not IDLE.

## Operation
- The operand register (64*WIDTH) loads only on accept, which is `issue_valid & issue_ready` at the clock edge.
- FSM states:
  - IDLE: `issue_ready`=1 unless `flush`. Moves to ISSUE on accept; quarter counter q is set to 0.
  - ISSUE: `lane_valid`=1 and `lane_data`=operand quarter q; q increments each cycle. Moves to DRAIN after q=3.
  - DRAIN: waits LATENCY cycles (drain counter); `lane_valid`=0. Moves to DONE.
  - DONE: `done`=1 for exactly one cycle. Moves to IDLE.
- Valid delay line: a LATENCY-stage shift register fed by `lane_valid`. Its output drives both `out_wr_en` and `out_shift_en`, so each returning quarter shifts into the top line and all lines advance together.
- After four shifts the collection register holds quarter 0 in its lowest 16 lanes and quarter 3 in its highest.
- Exactly four shift pulses per accepted wavefront; never more, never fewer unless flushed.
- `flush`, in any state:
  - Next state is IDLE; the delay line is cleared and q is cleared.
  - No further `out_shift_en` or `done` for that wavefront.
  - `issue_ready` is 0 in any cycle `flush` is 1, so flush wins over a simultaneous issue.
- `issue_valid` outside IDLE is ignored, and `issue_data` is not sampled.
- Reset values: state IDLE, delay line 0, operand register 0. Outputs: `issue_ready`=1, `busy`=0, `lane_valid`=0, `lane_data`=0, `quarter_idx`=0, `out_wr_en`=0, `out_shift_en`=0, `done`=0.
- Reset asserted mid-wavefront drops all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
Accept at edge closing cycle T:
- `lane_valid`=1 in cycles T+1..T+4, with `quarter_idx` 0,1,2,3.
- `out_wr_en`=`out_shift_en`=1 in cycles T+1+LATENCY..T+4+LATENCY.
- `done`=1 in cycle T+5+LATENCY, the cycle the collection register output first holds all four quarters.
- `issue_ready`=1 again in cycle T+6+LATENCY. The minimum accept-to-accept period is 6+LATENCY cycles (8 for LATENCY=2).
- `busy`=1 from T+1 through T+5+LATENCY.
- Outputs are registered or decoded from registered state only; there is no combinational path from `issue_valid` to any output except `issue_ready` via `flush`.

## Test plan
WIDTH=8, LATENCY=2:
- Reset, then idle 3 cycles -> `issue_ready`=1, all other outputs 0, `done` never pulses.
- Accept at T with lane i = i (bytes 0x00..0x3F) -> `lane_data` = 0x0F..0x00, 0x1F..0x10, 0x2F..0x20, 0x3F..0x30 in cycles T+1..T+4. Shift enables high T+3..T+6, `done` at T+7, and the collection register reads 0x3F..0x00.
- Back-to-back: hold `issue_valid`=1 continuously -> second accept at T+8, never earlier. `issue_data` changes during T+1..T+7 have no effect on the first wavefront.
- `flush` in cycle T+3, i.e. during ISSUE at q=2 -> `lane_valid`=0 from T+4. No shift enable after T+3 and no `done`; `issue_ready`=1 at T+4.
- `flush` and `issue_valid` together in IDLE -> not accepted (`busy` stays 0). Accept succeeds the next cycle once `flush` drops.
- Async `rst` pulse mid-cycle at T+5 -> all outputs drop to reset values before the next edge. No `done`; a fresh wavefront then completes normally.

Source files
------------

// File: rtl/alu_quarter_sequencer.sv
// rtl/alu_quarter_sequencer.sv - issues a 64-lane operand as four 16-lane quarters to a SIMD ALU
// and drives the collection register's write/shift enables from a latency-matched valid line.
module alu_quarter_sequencer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [64*WIDTH-1:0]   issue_data,
    input  logic                  flush,
    output logic                  lane_valid,
    output logic [16*WIDTH-1:0]   lane_data,
    output logic [1:0]            quarter_idx,
    output logic                  out_wr_en,
    output logic                  out_shift_en,
    output logic                  done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(LATENCY - 1);

    state_t                state_q;
    logic [1:0]            q_q;
    logic [3:0]            drain_q;
    logic [LATENCY-1:0]    dly_q;
    logic [64*WIDTH-1:0]   opnd_q;

    // Every output decodes registered state, so an async reset clears them at once.
    assign issue_ready  = (state_q == S_IDLE) && !flush;
    assign lane_valid   = (state_q == S_ISSUE);
    assign quarter_idx  = q_q;
    assign out_wr_en    = dly_q[LATENCY-1];
    assign out_shift_en = dly_q[LATENCY-1];
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);

    always_comb begin
        lane_data = '0;
        if (lane_valid) begin
            case (q_q)
                2'd0:    lane_data = opnd_q[0*16*WIDTH +: 16*WIDTH];
                2'd1:    lane_data = opnd_q[1*16*WIDTH +: 16*WIDTH];
                2'd2:    lane_data = opnd_q[2*16*WIDTH +: 16*WIDTH];
                default: lane_data = opnd_q[3*16*WIDTH +: 16*WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= 2'd0;
            drain_q <= 4'd0;
            dly_q   <= '0;
            opnd_q  <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            q_q     <= 2'd0;
            drain_q <= 4'd0;
            dly_q   <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                dly_q[i] <= dly_q[i-1];
            end
            dly_q[0] <= lane_valid;
            case (state_q)
                S_IDLE: begin
                    if (issue_valid) begin
                        opnd_q  <= issue_data;
                        q_q     <= 2'd0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // q wraps 3 -> 0, leaving quarter_idx at 0 outside ISSUE
                    q_q <= q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        drain_q <= 4'd0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
